// File: rtl/uart_pkg.sv
// uart_pkg: constants, FSM encoding and a parameter legality
// check shared by the UART transmit/receive blocks. No ports.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // 50 MHz / 115200 baud
    localparam int DEFAULT_CLK_DIV = 434;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } tx_state_t;

    function automatic bit tx_params_ok(
        input int clk_div,
        input int data_bits,
        input int parity,
        input int stop_bits,
        input int fifo_depth
    );
        bit ok;
        ok = 1'b1;
        if (clk_div < 2) ok = 1'b0;
        if (data_bits < 5 || data_bits > 9) ok = 1'b0;
        if (parity < PAR_NONE || parity > PAR_ODD) ok = 1'b0;
        if (stop_bits < 1 || stop_bits > 2) ok = 1'b0;
        if (fifo_depth < 2) ok = 1'b0;
        if ((fifo_depth & (fifo_depth - 1)) != 0) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with registered full flag and count.
// Ports: clk, rst (sync, active high), wr_en/wr_data, rd_en/rd_data,
//        full, empty, drop (rejected-write pulse), count.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic                     drop,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             full_q;
    logic             drop_q;
    logic             wr_ok;
    logic             rd_ok;

    assign wr_ok = wr_en && !full_q;
    assign rd_ok = rd_en && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
            drop_q  <= wr_en && full_q;
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign full    = full_q;
    assign empty   = (count_q == '0);
    assign drop    = drop_q;
    assign count   = count_q;

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: self-timed UART transmitter with input FIFO.
// Ports: CLK, RST (sync, active high), DATA/DATA_READY in, FULL, DROP, TXD, IDLE out.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = PAR_NONE,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [DATA_BITS-1:0] DATA,
    input  logic                 DATA_READY,
    output logic                 FULL,
    output logic                 DROP,
    output logic                 TXD,
    output logic                 IDLE
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS);
    localparam int NW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          HAS_PAR   = (PARITY != PAR_NONE);
    localparam logic          ODD_PAR   = (PARITY == PAR_ODD);

    if (!tx_params_ok(CLK_DIV, DATA_BITS, PARITY, STOP_BITS, FIFO_DEPTH))
    begin : g_bad_params
        $error("uart_tx_param: illegal parameter set");
    end

    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 fifo_empty;
    logic [NW-1:0]        fifo_count;
    logic                 pop;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (DATA_READY),
        .wr_data (DATA),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (FULL),
        .empty   (fifo_empty),
        .drop    (DROP),
        .count   (fifo_count)
    );

    tx_state_t            state_q;
    tx_state_t            state_d;
    logic [CW-1:0]        baud_q;
    logic [CW-1:0]        baud_d;
    logic [BW-1:0]        bit_q;
    logic [BW-1:0]        bit_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic                 par_q;
    logic                 par_d;
    logic                 baud_end;
    logic                 txd_d;
    logic                 txd_q;
    logic                 idle_q;

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;

        // the divider free-runs while a frame is in flight
        if (state_q != S_IDLE) begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd_data;
                    par_d   = (^fifo_rd_data) ^ ODD_PAR;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = HAS_PAR ? S_PAR : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PAR: begin
                if (baud_end) begin
                    bit_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    if (bit_q != STOP_LAST) begin
                        bit_d = bit_q + 1'b1;
                    end else if (!fifo_empty) begin
                        // chain the next frame with no idle gap
                        pop     = 1'b1;
                        shift_d = fifo_rd_data;
                        par_d   = (^fifo_rd_data) ^ ODD_PAR;
                        bit_d   = '0;
                        state_d = S_START;
                    end else begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_q[0];
            S_PAR:   txd_d = par_q;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            idle_q  <= (state_q == S_IDLE) && (fifo_count == '0);
        end
    end

    assign TXD  = txd_q;
    assign IDLE = idle_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed bench for uart_tx_param across
// 8N1, 8E1, 8O1 and 7N2 configurations with CLK_DIV=4.
module tb_uart_tx_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] a_data = '0;
    logic       a_dr   = 1'b0;
    logic       a_full, a_drop, a_txd, a_idle;
    logic [7:0] e_data = '0;
    logic       e_dr   = 1'b0;
    logic       e_full, e_drop, e_txd, e_idle;
    logic [7:0] o_data = '0;
    logic       o_dr   = 1'b0;
    logic       o_full, o_drop, o_txd, o_idle;
    logic [6:0] s_data = '0;
    logic       s_dr   = 1'b0;
    logic       s_full, s_drop, s_txd, s_idle;

    int checks = 0;
    int errors = 0;

    logic txd_tr  [256];
    logic idle_tr [256];
    logic full_tr [256];
    logic drop_tr [256];
    logic txd2_tr [256];
    logic idle2_tr[256];

    uart_tx_param #(
        .CLK_DIV(4), .DATA_BITS(8), .PARITY(0),
        .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .CLK(clk), .RST(rst), .DATA(a_data), .DATA_READY(a_dr),
        .FULL(a_full), .DROP(a_drop), .TXD(a_txd), .IDLE(a_idle)
    );

    uart_tx_param #(
        .CLK_DIV(4), .DATA_BITS(8), .PARITY(1),
        .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_e (
        .CLK(clk), .RST(rst), .DATA(e_data), .DATA_READY(e_dr),
        .FULL(e_full), .DROP(e_drop), .TXD(e_txd), .IDLE(e_idle)
    );

    uart_tx_param #(
        .CLK_DIV(4), .DATA_BITS(8), .PARITY(2),
        .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_o (
        .CLK(clk), .RST(rst), .DATA(o_data), .DATA_READY(o_dr),
        .FULL(o_full), .DROP(o_drop), .TXD(o_txd), .IDLE(o_idle)
    );

    uart_tx_param #(
        .CLK_DIV(4), .DATA_BITS(7), .PARITY(0),
        .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut_s (
        .CLK(clk), .RST(rst), .DATA(s_data), .DATA_READY(s_dr),
        .FULL(s_full), .DROP(s_drop), .TXD(s_txd), .IDLE(s_idle)
    );

    // Expected line level i cycles after the accepting edge, 4 cycles/bit.
    function automatic logic exp_txd(input int i, input logic [8:0] d,
                                     input int nb, input int par);
        int  p;
        logic pb;
        if (i < 2) return 1'b1;
        p = (i - 2) / 4;
        if (p == 0) return 1'b0;
        if (p <= nb) return d[p-1];
        if (par != 0 && p == nb + 1) begin
            pb = 1'b0;
            for (int k = 0; k < nb; k++) pb = pb ^ d[k];
            return (par == 2) ? ~pb : pb;
        end
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_dr = i[0];
            a_data = 8'h3C;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (a_txd !== 1'b1) begin
                errors++;
                $display("FAIL reset_txd cyc=%0d got=%b exp=1", i, a_txd);
            end
            checks++;
            if (a_idle !== 1'b1) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=1", i, a_idle);
            end
            checks++;
            if (a_full !== 1'b0) begin
                errors++;
                $display("FAIL reset_full cyc=%0d got=%b exp=0", i, a_full);
            end
            checks++;
            if (a_drop !== 1'b0) begin
                errors++;
                $display("FAIL reset_drop cyc=%0d got=%b exp=0", i, a_drop);
            end
        end
        rst  = 1'b0;
        a_dr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (a_txd !== 1'b1 || a_idle !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_quiet cyc=%0d txd=%b idle=%b exp=1/1",
                         i, a_txd, a_idle);
            end
        end
    endtask

    task automatic test_frame_8n1();
        for (int i = 0; i < 48; i++) begin
            a_dr   = (i == 0);
            a_data = 8'hA5;
            @(posedge clk);
            @(negedge clk);
            txd_tr[i]  = a_txd;
            idle_tr[i] = a_idle;
        end
        for (int i = 0; i < 48; i++) begin
            checks++;
            if (txd_tr[i] !== exp_txd(i, 9'h0A5, 8, 0)) begin
                errors++;
                $display("FAIL a5_txd cyc=%0d got=%b exp=%b",
                         i, txd_tr[i], exp_txd(i, 9'h0A5, 8, 0));
            end
        end
        checks++;
        if (txd_tr[1] !== 1'b1 || txd_tr[2] !== 1'b0 || txd_tr[5] !== 1'b0) begin
            errors++;
            $display("FAIL a5_start_edge got=%b%b%b exp=100",
                     txd_tr[1], txd_tr[2], txd_tr[5]);
        end
        checks++;
        if (txd_tr[41] !== 1'b1 || txd_tr[37] !== 1'b1) begin
            errors++;
            $display("FAIL a5_stop got=%b%b exp=11", txd_tr[37], txd_tr[41]);
        end
        checks++;
        if (idle_tr[0] !== 1'b1 || idle_tr[1] !== 1'b0) begin
            errors++;
            $display("FAIL a5_idle_fall got=%b%b exp=10", idle_tr[0], idle_tr[1]);
        end
        checks++;
        if (idle_tr[41] !== 1'b0 || idle_tr[42] !== 1'b1) begin
            errors++;
            $display("FAIL a5_idle_rise got=%b%b exp=01", idle_tr[41], idle_tr[42]);
        end
    endtask

    task automatic test_parity();
        for (int i = 0; i < 50; i++) begin
            e_dr   = (i == 0);
            o_dr   = (i == 0);
            e_data = 8'h07;
            o_data = 8'h07;
            @(posedge clk);
            @(negedge clk);
            txd_tr[i]   = e_txd;
            idle_tr[i]  = e_idle;
            txd2_tr[i]  = o_txd;
            idle2_tr[i] = o_idle;
        end
        for (int i = 0; i < 50; i++) begin
            checks++;
            if (txd_tr[i] !== exp_txd(i, 9'h007, 8, 1)) begin
                errors++;
                $display("FAIL even_txd cyc=%0d got=%b exp=%b",
                         i, txd_tr[i], exp_txd(i, 9'h007, 8, 1));
            end
            checks++;
            if (txd2_tr[i] !== exp_txd(i, 9'h007, 8, 2)) begin
                errors++;
                $display("FAIL odd_txd cyc=%0d got=%b exp=%b",
                         i, txd2_tr[i], exp_txd(i, 9'h007, 8, 2));
            end
        end
        checks++;
        if (txd_tr[38] !== 1'b1 || txd_tr[41] !== 1'b1) begin
            errors++;
            $display("FAIL even_par_bit got=%b%b exp=11", txd_tr[38], txd_tr[41]);
        end
        checks++;
        if (txd2_tr[38] !== 1'b0 || txd2_tr[41] !== 1'b0) begin
            errors++;
            $display("FAIL odd_par_bit got=%b%b exp=00", txd2_tr[38], txd2_tr[41]);
        end
        checks++;
        if (idle_tr[45] !== 1'b0 || idle_tr[46] !== 1'b1) begin
            errors++;
            $display("FAIL even_len44 got=%b%b exp=01", idle_tr[45], idle_tr[46]);
        end
        checks++;
        if (idle2_tr[45] !== 1'b0 || idle2_tr[46] !== 1'b1) begin
            errors++;
            $display("FAIL odd_len44 got=%b%b exp=01", idle2_tr[45], idle2_tr[46]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [6];
        logic [8:0] w;
        logic       e;
        int         k;
        words[0] = 8'h11;
        words[1] = 8'h22;
        words[2] = 8'h33;
        words[3] = 8'h44;
        words[4] = 8'h55;
        words[5] = 8'h66;
        for (int i = 0; i < 210; i++) begin
            a_dr   = (i < 6);
            a_data = (i < 6) ? words[i] : 8'h00;
            @(posedge clk);
            @(negedge clk);
            txd_tr[i]  = a_txd;
            idle_tr[i] = a_idle;
            full_tr[i] = a_full;
            drop_tr[i] = a_drop;
        end
        checks++;
        if (full_tr[3] !== 1'b0 || full_tr[4] !== 1'b1 || full_tr[5] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_full got=%b%b%b exp=011",
                     full_tr[3], full_tr[4], full_tr[5]);
        end
        checks++;
        if (drop_tr[4] !== 1'b0 || drop_tr[5] !== 1'b1 || drop_tr[6] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drop got=%b%b%b exp=010",
                     drop_tr[4], drop_tr[5], drop_tr[6]);
        end
        checks++;
        if (full_tr[41] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full_clear got=%b exp=0", full_tr[41]);
        end
        for (int i = 0; i < 210; i++) begin
            k = (i < 2) ? 0 : (i - 2) / 40;
            if (k < 5) begin
                w = {1'b0, words[k]};
                e = exp_txd(i - 40 * k, w, 8, 0);
            end else begin
                e = 1'b1;
            end
            checks++;
            if (txd_tr[i] !== e) begin
                errors++;
                $display("FAIL b2b_txd cyc=%0d got=%b exp=%b", i, txd_tr[i], e);
            end
        end
        checks++;
        if (idle_tr[201] !== 1'b0 || idle_tr[202] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_end got=%b%b exp=01", idle_tr[201], idle_tr[202]);
        end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 90; i++) begin
            a_dr   = (i < 5);
            a_data = (i == 0) ? 8'hA5 : 8'(i);
            rst    = (i == 19);
            @(posedge clk);
            @(negedge clk);
            txd_tr[i]  = a_txd;
            idle_tr[i] = a_idle;
            full_tr[i] = a_full;
        end
        rst = 1'b0;
        checks++;
        if (txd_tr[18] !== 1'b0 || full_tr[18] !== 1'b1 || idle_tr[18] !== 1'b0) begin
            errors++;
            $display("FAIL mid_before txd/full/idle got=%b%b%b exp=010",
                     txd_tr[18], full_tr[18], idle_tr[18]);
        end
        checks++;
        if (txd_tr[19] !== 1'b1 || idle_tr[19] !== 1'b1 || full_tr[19] !== 1'b0) begin
            errors++;
            $display("FAIL mid_abort txd/idle/full got=%b%b%b exp=110",
                     txd_tr[19], idle_tr[19], full_tr[19]);
        end
        for (int i = 20; i < 90; i++) begin
            checks++;
            if (txd_tr[i] !== 1'b1 || idle_tr[i] !== 1'b1) begin
                errors++;
                $display("FAIL mid_quiet cyc=%0d txd=%b idle=%b exp=1/1",
                         i, txd_tr[i], idle_tr[i]);
            end
        end
    endtask

    task automatic test_7n2_loopback();
        int         start;
        logic [6:0] rx;
        for (int i = 0; i < 48; i++) begin
            s_dr   = (i == 0);
            s_data = 7'h55;
            @(posedge clk);
            @(negedge clk);
            txd_tr[i]  = s_txd;
            idle_tr[i] = s_idle;
        end
        for (int i = 0; i < 48; i++) begin
            checks++;
            if (txd_tr[i] !== exp_txd(i, 9'h055, 7, 0)) begin
                errors++;
                $display("FAIL 7n2_txd cyc=%0d got=%b exp=%b",
                         i, txd_tr[i], exp_txd(i, 9'h055, 7, 0));
            end
        end
        checks++;
        if (idle_tr[41] !== 1'b0 || idle_tr[42] !== 1'b1) begin
            errors++;
            $display("FAIL 7n2_len40 got=%b%b exp=01", idle_tr[41], idle_tr[42]);
        end
        // mid-bit sampling receiver recovering the payload from the line
        start = -1;
        for (int i = 0; i < 48; i++) begin
            if (start < 0 && txd_tr[i] === 1'b0) start = i;
        end
        checks++;
        if (start != 2) begin
            errors++;
            $display("FAIL 7n2_start got=%0d exp=2", start);
        end else begin
            rx = '0;
            for (int b = 0; b < 7; b++) rx[b] = txd_tr[start + 4 * (b + 1) + 2];
            checks++;
            if (rx !== 7'h55) begin
                errors++;
                $display("FAIL 7n2_loopback got=%h exp=55", rx);
            end
            checks++;
            if (txd_tr[start + 34] !== 1'b1 || txd_tr[start + 38] !== 1'b1) begin
                errors++;
                $display("FAIL 7n2_stops got=%b%b exp=11",
                         txd_tr[start + 34], txd_tr[start + 38]);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_frame_8n1();
        test_parity();
        test_back_to_back();
        test_reset_midframe();
        test_7n2_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised successor to uart_send. It is a self-timed UART transmitter with an internal baud divider, so no external baud/UART_CLK strobe is needed. Data width, parity mode and stop-bit count are configurable, and a small input FIFO decouples the producer from line timing. It sits between any byte producer (camera/debug logic on the CLK1 domain) and the TXD pin, and is drop-in paired with uart_receive for loopback benches.

Parameters:
CLK_DIV, 434, CLK cycles per bit (>=2); 434 = 50 MHz / 115200
DATA_BITS, 8, payload bits per frame (5..9), sent LSB first
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame (1 or 2)
FIFO_DEPTH, 4, input FIFO entries (power of two, >=2)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
DATA  in  DATA_BITS  word to enqueue
DATA_READY  in  1  write strobe; one word enqueued per cycle high
FULL  out  1  FIFO full (registered); writes while high are dropped
DROP  out  1  one-cycle pulse when a write is rejected because FULL=1
TXD  out  1  serial line, idle high
IDLE  out  1  high when FSM is in IDLE and FIFO is empty

Behaviour:
- Clocking: one clock, CLK. RST is synchronous and active-high, sampled on the rising edge of CLK.
- Reset values: TXD=1, IDLE=1, FULL=0, DROP=0. FIFO is emptied, FSM goes to IDLE, baud counter is 0. Reset mid-frame aborts the frame; TXD is 1 on the cycle after RST is sampled.
- Write rule: a write is accepted iff DATA_READY=1 and FULL=0 (registered value). The written word is visible to the FSM on the next cycle. A write and a pop may occur in the same cycle; the count is then unchanged.
- Rejected write: DATA_READY=1 with FULL=1 pulses DROP for one cycle, and FIFO contents are unchanged.
- FSM states:
  - IDLE: TXD=1. When the FIFO is non-empty, pop the head into the shift register, compute parity, clear the baud counter, and go to START.
  - START: TXD=0 for CLK_DIV cycles, then go to DATA.
  - DATA: TXD=shift[0], shifting right each bit period, for DATA_BITS periods. Then go to PAR if PARITY!=0, else STOP.
  - PAR: TXD = XOR of the data bits (even), or its inverse (odd), for one period. Then go to STOP.
  - STOP: TXD=1 for STOP_BITS*CLK_DIV cycles. On the last cycle, if the FIFO is non-empty, pop and go directly to START (no gap); otherwise go to IDLE.
- Baud counter: runs 0..CLK_DIV-1 only while not in IDLE and is cleared on every frame start. Each bit therefore lasts exactly CLK_DIV cycles.
- Latency: with an idle and empty block, a write accepted at cycle n makes TXD fall at cycle n+2.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLK_DIV cycles.
- IDLE timing: IDLE is deasserted from cycle n+1 of the first write. It re-asserts on the cycle after the final stop bit completes, provided the FIFO is empty.
- Unused upper DATA bits do not exist; width is exactly DATA_BITS.
- Illegal parameter values stop elaboration with an error (generate-time check).

Decomposition:
- Package uart_pkg holds:
  - parity constants PAR_NONE/PAR_EVEN/PAR_ODD
  - FSM state encoding (S_IDLE, S_START, S_DATA, S_PAR, S_STOP)
  - the default-divider constant
- Sub-module uart_tx_fifo: synchronous FIFO (WIDTH, DEPTH) with wr/rd/full/empty and a registered count. It is reusable by a future uart_rx_param.

Test Plan:
All scenarios use CLK_DIV=4 unless stated.
1. Reset: hold RST 10 cycles with DATA_READY toggling -> TXD=1, IDLE=1, FULL=0, DROP=0 every cycle, and no frame after release.
2. Write 0xA5 at cycle n (8N1) -> TXD=0 during n+2..n+5. Then bits 1,0,1,0,0,1,0,1, 4 cycles each, then stop high for 4 cycles. IDLE=1 at n+42.
3. PARITY=1 with 0x07 -> parity bit 1. PARITY=2 with 0x07 -> parity bit 0. Frame is 44 cycles.
4. FIFO_DEPTH=4, DATA_READY high 6 consecutive cycles n..n+5 -> 5 words accepted, FULL=1 at n+5, DROP pulse at n+5. Five frames go out back-to-back with no idle cycle between stop and start, in write order.
5. Assert RST during the 4th data bit -> TXD=1 the next cycle, IDLE=1, FULL=0. After release nothing is transmitted and the queued words are lost.
6. DATA_BITS=7, STOP_BITS=2, PARITY=0, write 0x55 -> frame is 40 cycles (10 periods) and the stop level holds 8 cycles. Loopback through uart_receive recovers 0x55.
